// File: rtl/line_follow_pkg.sv
// Shared types and helpers for the line-following steering controller.
package line_follow_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FOLLOW = 3'd1,
      NODE   = 3'd2,
      CROSS  = 3'd3,
      LOST   = 3'd4
   } state_t;

   localparam logic [1:0] LVL_WHITE = 2'd0;
   localparam logic [1:0] LVL_GREY  = 2'd1;
   localparam logic [1:0] LVL_BLACK = 2'd2;

   // Clamp a signed speed request into [0, max_spd].
   function automatic logic signed [23:0] sat_spd(input logic signed [23:0] v,
                                                  input logic signed [23:0] max_spd);
      if (v < 24'sd0)
         return 24'sd0;
      else if (v > max_spd)
         return max_spd;
      else
         return v;
   endfunction

endpackage

// File: rtl/lf_classifier.sv
// Stage 1: per-channel white/grey/black classification and weighted position error.
module lf_classifier
   import line_follow_pkg::*;
#(
   parameter int N_CH     = 3,
   parameter int ADC_W    = 12,
   parameter int WHITE_TH = 768,
   parameter int BLACK_TH = 1280
) (
   input  logic                    clk_50,
   input  logic                    rst_n,
   input  logic [N_CH*ADC_W-1:0]   ch_data,
   input  logic                    ch_valid,
   output logic signed [15:0]      err,
   output logic                    all_black,
   output logic                    all_white,
   output logic                    valid
);

   localparam logic [ADC_W-1:0] WHITE_C = ADC_W'(WHITE_TH);
   localparam logic [ADC_W-1:0] BLACK_C = ADC_W'(BLACK_TH);

   logic signed [15:0] sum;
   logic               blk;
   logic               wht;
   logic [1:0]         lvl;

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      sum = '0;
      blk = 1'b1;
      wht = 1'b1;
      lvl = LVL_WHITE;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_data[i*ADC_W +: ADC_W] < WHITE_C)
            lvl = LVL_WHITE;
         else if (ch_data[i*ADC_W +: ADC_W] > BLACK_C)
            lvl = LVL_BLACK;
         else
            lvl = LVL_GREY;
         sum = sum + 16'(2*i - (N_CH-1)) * $signed({14'd0, lvl});
         blk = blk & (lvl == LVL_BLACK);
         wht = wht & (lvl == LVL_WHITE);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         err       <= '0;
         all_black <= 1'b0;
         all_white <= 1'b0;
         valid     <= 1'b0;
      end else begin
         valid <= ch_valid;
         if (ch_valid) begin
            err       <= sum;
            all_black <= blk;
            all_white <= wht;
         end
      end
   end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following steering controller: stage-2 mode FSM, PD steering and motor outputs.
module line_follow_ctrl
   import line_follow_pkg::*;
#(
   parameter int N_CH       = 3,
   parameter int ADC_W      = 12,
   parameter int SPD_W      = 8,
   parameter int WHITE_TH   = 768,
   parameter int BLACK_TH   = 1280,
   parameter int BASE_L     = 70,
   parameter int BASE_R     = 73,
   parameter int KP         = 7,
   parameter int KD         = 2,
   parameter int MAX_SPD    = 255,
   parameter int NODE_SPD   = 1,
   parameter int SEARCH_SPD = 60,
   parameter int LOST_CNT   = 4,
   parameter int CLEAR_CNT  = 2
) (
   input  logic                  clk_50,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [N_CH*ADC_W-1:0] ch_data,
   input  logic                  ch_valid,
   input  logic                  node_ack,
   output logic [SPD_W-1:0]      lm,
   output logic [SPD_W-1:0]      rm,
   output logic                  node,
   output logic                  lost,
   output logic                  upd
);

   localparam logic signed [23:0] KP_S  = 24'(KP);
   localparam logic signed [23:0] KD_S  = 24'(KD);
   localparam logic signed [23:0] BL_S  = 24'(BASE_L);
   localparam logic signed [23:0] BR_S  = 24'(BASE_R);
   localparam logic signed [23:0] MAX_S = 24'(MAX_SPD);
   localparam logic [SPD_W-1:0]   BASE_L_C = SPD_W'(BASE_L);
   localparam logic [SPD_W-1:0]   BASE_R_C = SPD_W'(BASE_R);
   localparam logic [SPD_W-1:0]   NODE_C   = SPD_W'(NODE_SPD);
   localparam logic [SPD_W-1:0]   SEARCH_C = SPD_W'(SEARCH_SPD);
   localparam logic [7:0]         LOST_LAST  = 8'(LOST_CNT - 1);
   localparam logic [7:0]         CLEAR_LAST = 8'(CLEAR_CNT - 1);

   state_t             state;
   logic [7:0]         white_cnt;
   logic [7:0]         clear_cnt;
   logic signed [15:0] prev_err;
   logic signed [15:0] last_err;
   logic signed [15:0] s1_err;
   logic               s1_black;
   logic               s1_white;
   logic               s1_valid;
   logic signed [23:0] err_x, derr_x, steer, lm_sat, rm_sat;
   logic               unused_sat_bits;

   lf_classifier #(
      .N_CH(N_CH), .ADC_W(ADC_W), .WHITE_TH(WHITE_TH), .BLACK_TH(BLACK_TH)
   ) u_classifier (
      .clk_50(clk_50), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
      .err(s1_err), .all_black(s1_black), .all_white(s1_white), .valid(s1_valid)
   );

   always_comb begin
      err_x  = 24'(s1_err);
      derr_x = err_x - 24'(prev_err);
      steer  = KP_S * err_x + KD_S * derr_x;
      lm_sat = sat_spd(BL_S + steer, MAX_S);
      rm_sat = sat_spd(BR_S - steer, MAX_S);
   end

   assign unused_sat_bits = ^{lm_sat[23:SPD_W], rm_sat[23:SPD_W]};

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lm        <= '0;
         rm        <= '0;
         node      <= 1'b0;
         lost      <= 1'b0;
         upd       <= 1'b0;
         white_cnt <= '0;
         clear_cnt <= '0;
         prev_err  <= '0;
         last_err  <= '0;
      end else if (!enable) begin
         state     <= IDLE;
         lm        <= '0;
         rm        <= '0;
         node      <= 1'b0;
         lost      <= 1'b0;
         upd       <= 1'b0;
         white_cnt <= '0;
         clear_cnt <= '0;
      end else begin
         upd <= 1'b0;
         case (state)
            IDLE: begin
               state     <= FOLLOW;
               prev_err  <= '0;
               white_cnt <= '0;
            end
            FOLLOW: if (s1_valid) begin
               upd      <= 1'b1;
               prev_err <= s1_err;
               if (s1_black) begin
                  state     <= NODE;
                  node      <= 1'b1;
                  lm        <= NODE_C;
                  rm        <= NODE_C;
                  white_cnt <= '0;
               end else if (s1_white) begin
                  // Speeds hold while counting; last_err keeps the last seen line side.
                  if (white_cnt == LOST_LAST) begin
                     state     <= LOST;
                     lost      <= 1'b1;
                     white_cnt <= '0;
                     lm        <= (last_err < 0) ? '0 : SEARCH_C;
                     rm        <= (last_err < 0) ? SEARCH_C : '0;
                  end else begin
                     white_cnt <= white_cnt + 8'd1;
                  end
               end else begin
                  white_cnt <= '0;
                  last_err  <= s1_err;
                  lm        <= lm_sat[SPD_W-1:0];
                  rm        <= rm_sat[SPD_W-1:0];
               end
            end
            NODE: begin
               if (node_ack) begin
                  state     <= CROSS;
                  node      <= 1'b0;
                  lm        <= BASE_L_C;
                  rm        <= BASE_R_C;
                  clear_cnt <= '0;
                  upd       <= 1'b1;
               end else if (s1_valid) begin
                  upd <= 1'b1;
               end
            end
            CROSS: if (s1_valid) begin
               upd <= 1'b1;
               if (s1_black) begin
                  clear_cnt <= '0;
               end else if (clear_cnt == CLEAR_LAST) begin
                  state     <= FOLLOW;
                  prev_err  <= '0;
                  white_cnt <= '0;
                  clear_cnt <= '0;
               end else begin
                  clear_cnt <= clear_cnt + 8'd1;
               end
            end
            LOST: if (s1_valid) begin
               upd <= 1'b1;
               if (!s1_white) begin
                  state     <= FOLLOW;
                  lost      <= 1'b0;
                  lm        <= BASE_L_C;
                  rm        <= BASE_R_C;
                  prev_err  <= '0;
                  last_err  <= s1_err;
                  white_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Self-checking bench for line_follow_ctrl: directed scenarios plus randomized frames vs a frame-level model.
`timescale 1ns/1ps
module tb_line_follow_ctrl;

   localparam int N_CH  = 3;
   localparam int ADC_W = 12;
   localparam int SPD_W = 8;

   logic                  clk_50 = 1'b0;
   logic                  rst_n;
   logic                  enable;
   logic [N_CH*ADC_W-1:0] ch_data;
   logic                  ch_valid;
   logic                  node_ack;
   logic [SPD_W-1:0]      lm, rm, sat_lm, sat_rm;
   logic                  node, lost, upd;
   logic                  sat_node_unused, sat_lost_unused, sat_upd_unused;

   int n_cmp = 0;
   int n_bad = 0;

   // Frame-level reference model state
   string m_mode;
   int    m_lm, m_rm, m_node, m_lost, m_prev, m_last, m_white, m_clr;

   always #5 clk_50 = ~clk_50;

   line_follow_ctrl dut (
      .clk_50(clk_50), .rst_n(rst_n), .enable(enable), .ch_data(ch_data),
      .ch_valid(ch_valid), .node_ack(node_ack), .lm(lm), .rm(rm),
      .node(node), .lost(lost), .upd(upd)
   );

   line_follow_ctrl #(.KP(60)) dut_sat (
      .clk_50(clk_50), .rst_n(rst_n), .enable(enable), .ch_data(ch_data),
      .ch_valid(ch_valid), .node_ack(node_ack), .lm(sat_lm), .rm(sat_rm),
      .node(sat_node_unused), .lost(sat_lost_unused), .upd(sat_upd_unused)
   );

   function automatic logic [35:0] mk(input int a, input int b, input int c);
      logic [35:0] r;
      r = {12'(c), 12'(b), 12'(a)};
      return r;
   endfunction

   function automatic int clampi(input int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   function automatic int reading(input int lv);
      int pick;
      pick = $urandom_range(0, 7);
      if (lv == 0) return (pick == 0) ? 767 : $urandom_range(0, 767);
      if (lv == 2) return (pick == 0) ? 1281 : $urandom_range(1281, 4095);
      if (pick == 0) return 768;
      if (pick == 1) return 1280;
      return $urandom_range(769, 1279);
   endfunction

   function automatic logic [35:0] rand_frame();
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 2) return mk(reading(0), reading(0), reading(0));
      if (kind == 3) return mk(reading(2), reading(2), reading(2));
      return mk(reading($urandom_range(0, 2)), reading($urandom_range(0, 2)),
                reading($urandom_range(0, 2)));
   endfunction

   task automatic model_reset();
      m_mode = "IDLE"; m_lm = 0; m_rm = 0; m_node = 0; m_lost = 0;
      m_prev = 0; m_last = 0; m_white = 0; m_clr = 0;
   endtask

   task automatic model_enable_tick();
      if (m_mode == "IDLE") begin
         m_mode = "FOLLOW"; m_prev = 0; m_white = 0;
      end
   endtask

   task automatic model_ack();
      if (m_mode == "NODE") begin
         m_mode = "CROSS"; m_node = 0; m_lm = 70; m_rm = 73; m_clr = 0;
      end
   endtask

   task automatic model_frame(input logic [35:0] d);
      int e = 0, nb = 0, nw = 0, r, lv, steer;
      for (int i = 0; i < 3; i++) begin
         r  = int'(d[i*12 +: 12]);
         lv = (r < 768) ? 0 : ((r > 1280) ? 2 : 1);
         e += (2*i - 2) * lv;
         if (lv == 2) nb++;
         if (lv == 0) nw++;
      end
      if (m_mode == "FOLLOW") begin
         if (nb == 3) begin
            m_mode = "NODE"; m_node = 1; m_lm = 1; m_rm = 1; m_white = 0;
         end else if (nw == 3) begin
            m_white++;
            if (m_white == 4) begin
               m_mode = "LOST"; m_lost = 1; m_white = 0;
               m_lm = (m_last < 0) ? 0 : 60;
               m_rm = (m_last < 0) ? 60 : 0;
            end
         end else begin
            steer = 7*e + 2*(e - m_prev);
            m_lm = clampi(70 + steer);
            m_rm = clampi(73 - steer);
            m_white = 0;
            m_last = e;
         end
         m_prev = e;
      end else if (m_mode == "CROSS") begin
         if (nb == 3) m_clr = 0;
         else begin
            m_clr++;
            if (m_clr == 2) begin
               m_mode = "FOLLOW"; m_prev = 0; m_white = 0; m_clr = 0;
            end
         end
      end else if (m_mode == "LOST") begin
         if (nw != 3) begin
            m_mode = "FOLLOW"; m_lost = 0; m_lm = 70; m_rm = 73;
            m_prev = 0; m_last = e; m_white = 0;
         end
      end
   endtask

   // Drive one frame and return 1 ns after its stage-2 edge.
   task automatic send_frame(input logic [35:0] d);
      ch_data  = d;
      ch_valid = 1'b1;
      @(posedge clk_50); #1;
      ch_valid = 1'b0;
      @(posedge clk_50); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; ch_valid = 1'b0; node_ack = 1'b0; ch_data = '0;
      repeat (2) @(posedge clk_50);
      #1;
      n_cmp++; if (lm !== 8'd0)   begin n_bad++; $display("FAIL reset_lm got %0d want 0", lm); end
      n_cmp++; if (rm !== 8'd0)   begin n_bad++; $display("FAIL reset_rm got %0d want 0", rm); end
      n_cmp++; if ({node, lost, upd} !== 3'b000)
         begin n_bad++; $display("FAIL reset_flags got %b want 000", {node, lost, upd}); end
      rst_n = 1'b1; enable = 1'b1;
      repeat (2) @(posedge clk_50);
      #1;
   endtask

   task automatic test_centre();
      ch_data = mk(600, 1500, 600); ch_valid = 1'b1;
      @(posedge clk_50); #1;
      ch_valid = 1'b0;
      n_cmp++; if ({lm, upd} !== {8'd0, 1'b0})
         begin n_bad++; $display("FAIL centre_early got lm=%0d upd=%b want lm=0 upd=0", lm, upd); end
      @(posedge clk_50); #1;
      n_cmp++; if (lm !== 8'd70) begin n_bad++; $display("FAIL centre_lm got %0d want 70", lm); end
      n_cmp++; if (rm !== 8'd73) begin n_bad++; $display("FAIL centre_rm got %0d want 73", rm); end
      n_cmp++; if (upd !== 1'b1) begin n_bad++; $display("FAIL centre_upd got %b want 1", upd); end
      @(posedge clk_50); #1;
      n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL centre_upd_once got %b want 0", upd); end
   endtask

   task automatic test_saturation();
      int exp_l, exp_r;
      // Right-hand line with prev_err = 0, gain 60: 70 + 60*4 + 2*4 clamps high, 73 - 248 clamps low.
      exp_l = clampi(70 + 60*4 + 2*4);
      exp_r = clampi(73 - (60*4 + 2*4));
      send_frame(mk(600, 600, 1500));
      n_cmp++; if (sat_lm !== 8'(exp_l)) begin n_bad++; $display("FAIL sat_lm got %0d want %0d", sat_lm, exp_l); end
      n_cmp++; if (sat_rm !== 8'(exp_r)) begin n_bad++; $display("FAIL sat_rm got %0d want %0d", sat_rm, exp_r); end
      n_cmp++; if ({lm, rm} !== {8'd106, 8'd37})
         begin n_bad++; $display("FAIL right_main got %0d/%0d want 106/37", lm, rm); end
      send_frame(mk(600, 1500, 600));
      n_cmp++; if ({lm, rm} !== {8'd62, 8'd81})
         begin n_bad++; $display("FAIL recentre got %0d/%0d want 62/81", lm, rm); end
   endtask

   task automatic test_left_two();
      send_frame(mk(1500, 600, 600));
      n_cmp++; if ({lm, rm} !== {8'd34, 8'd109})
         begin n_bad++; $display("FAIL left1 got %0d/%0d want 34/109", lm, rm); end
      send_frame(mk(1500, 600, 600));
      n_cmp++; if ({lm, rm} !== {8'd42, 8'd101})
         begin n_bad++; $display("FAIL left2 got %0d/%0d want 42/101", lm, rm); end
   endtask

   task automatic test_thresholds();
      // 768 and 1280 are grey, 1281 black: err = 2, derr = 6, steer = 26.
      send_frame(mk(768, 1280, 1281));
      n_cmp++; if ({lm, rm} !== {8'd96, 8'd47})
         begin n_bad++; $display("FAIL thresh_hi got %0d/%0d want 96/47", lm, rm); end
      // 1280 grey, 767 white: err = -2, derr = -4, steer = -22.
      send_frame(mk(1280, 767, 600));
      n_cmp++; if ({lm, rm} !== {8'd48, 8'd95})
         begin n_bad++; $display("FAIL thresh_lo got %0d/%0d want 48/95", lm, rm); end
   endtask

   task automatic test_ack_ignored();
      node_ack = 1'b1;
      @(posedge clk_50); #1;
      node_ack = 1'b0;
      send_frame(mk(600, 1500, 600));
      n_cmp++; if ({node, lm, rm} !== {1'b0, 8'd74, 8'd69})
         begin n_bad++; $display("FAIL ack_ignored got node=%b %0d/%0d want node=0 74/69", node, lm, rm); end
   endtask

   task automatic test_node();
      send_frame(mk(1500, 1500, 1500));
      n_cmp++; if ({node, lm, rm} !== {1'b1, 8'd1, 8'd1})
         begin n_bad++; $display("FAIL node_enter got node=%b %0d/%0d want node=1 1/1", node, lm, rm); end
      node_ack = 1'b1; ch_valid = 1'b1; ch_data = mk(1500, 1500, 1500);
      @(posedge clk_50); #1;
      node_ack = 1'b0; ch_valid = 1'b0;
      n_cmp++; if ({node, lm, rm} !== {1'b0, 8'd70, 8'd73})
         begin n_bad++; $display("FAIL node_ack got node=%b %0d/%0d want node=0 70/73", node, lm, rm); end
      @(posedge clk_50); #1;
      n_cmp++; if ({node, lm, rm} !== {1'b0, 8'd70, 8'd73})
         begin n_bad++; $display("FAIL cross_black got node=%b %0d/%0d want node=0 70/73", node, lm, rm); end
      send_frame(mk(600, 1500, 600));
      send_frame(mk(600, 1500, 600));
      n_cmp++; if ({lm, rm} !== {8'd70, 8'd73})
         begin n_bad++; $display("FAIL cross_exit got %0d/%0d want 70/73", lm, rm); end
      send_frame(mk(1500, 600, 600));
      n_cmp++; if ({lm, rm} !== {8'd34, 8'd109})
         begin n_bad++; $display("FAIL follow_after_cross got %0d/%0d want 34/109", lm, rm); end
   endtask

   task automatic test_lost();
      send_frame(mk(1500, 600, 600));
      for (int k = 0; k < 3; k++) send_frame(mk(100, 100, 100));
      n_cmp++; if ({lost, lm, rm} !== {1'b0, 8'd42, 8'd101})
         begin n_bad++; $display("FAIL white_hold got lost=%b %0d/%0d want lost=0 42/101", lost, lm, rm); end
      send_frame(mk(100, 100, 100));
      n_cmp++; if ({lost, lm, rm} !== {1'b1, 8'd0, 8'd60})
         begin n_bad++; $display("FAIL lost_left got lost=%b %0d/%0d want lost=1 0/60", lost, lm, rm); end
      send_frame(mk(600, 1500, 600));
      n_cmp++; if ({lost, lm, rm} !== {1'b0, 8'd70, 8'd73})
         begin n_bad++; $display("FAIL lost_recover got lost=%b %0d/%0d want lost=0 70/73", lost, lm, rm); end
      send_frame(mk(600, 600, 1500));
      for (int k = 0; k < 4; k++) send_frame(mk(100, 100, 100));
      n_cmp++; if ({lost, lm, rm} !== {1'b1, 8'd60, 8'd0})
         begin n_bad++; $display("FAIL lost_right got lost=%b %0d/%0d want lost=1 60/0", lost, lm, rm); end
      send_frame(mk(600, 1500, 600));
   endtask

   task automatic test_enable_drop();
      send_frame(mk(1500, 600, 600));
      enable = 1'b0;
      @(posedge clk_50); #1;
      n_cmp++; if ({lm, rm} !== {8'd0, 8'd0})
         begin n_bad++; $display("FAIL enable_drop got %0d/%0d want 0/0", lm, rm); end
      enable = 1'b1;
      repeat (2) @(posedge clk_50);
      #1;
   endtask

   task automatic test_reset_in_node();
      send_frame(mk(1500, 1500, 1500));
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if ({node, lost, upd, lm, rm} !== {3'b000, 8'd0, 8'd0})
         begin n_bad++; $display("FAIL async_reset got node=%b %0d/%0d want node=0 0/0", node, lm, rm); end
      @(negedge clk_50);
      rst_n = 1'b1;
      repeat (2) @(posedge clk_50);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [35:0] fr[$];
      int n;
      rst_n = 1'b0;
      @(negedge clk_50);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk_50); #1;
      model_enable_tick();
      for (int burst = 0; burst < 40; burst++) begin
         fr.delete();
         n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) fr.push_back(rand_frame());
         for (int step = 0; step <= n; step++) begin
            if (step < n) begin ch_data = fr[step]; ch_valid = 1'b1; end
            else ch_valid = 1'b0;
            @(posedge clk_50); #1;
            if (step >= 1) begin
               model_frame(fr[step-1]);
               n_cmp++;
               if ({lm, rm, node, lost, upd} !== {8'(m_lm), 8'(m_rm), 1'(m_node), 1'(m_lost), 1'b1}) begin
                  n_bad++;
                  $display("FAIL rand_b%0d_f%0d got %0d/%0d n=%b l=%b u=%b want %0d/%0d n=%0d l=%0d u=1",
                           burst, step-1, lm, rm, node, lost, upd, m_lm, m_rm, m_node, m_lost);
               end
            end
         end
         if (m_node == 1) begin
            node_ack = 1'b1;
            @(posedge clk_50); #1;
            node_ack = 1'b0;
            model_ack();
            n_cmp++;
            if ({lm, rm, node} !== {8'(m_lm), 8'(m_rm), 1'(m_node)}) begin
               n_bad++;
               $display("FAIL rand_ack_b%0d got %0d/%0d n=%b want %0d/%0d n=%0d",
                        burst, lm, rm, node, m_lm, m_rm, m_node);
            end
         end
      end
      @(posedge clk_50); #1;
      n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL rand_upd_idle got %b want 0", upd); end
   endtask

   initial begin
      test_reset();
      test_centre();
      test_saturation();
      test_left_two();
      test_thresholds();
      test_ack_ignored();
      test_node();
      test_lost();
      test_enable_drop();
      test_reset_in_node();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
